mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Parametrised iterative multiply/divide unit for the datapath's HI/LO register pair.
//   Supports signed and unsigned MULT/DIV selected per operation.
//   Handshake: start/busy/done. The result pair hi/lo holds until the next accepted start.
//   Produces one result every WIDTH+2 cycles and sits beside the ALU, feeding the HI/LO write path.
// PARAMETERS
//   WIDTH  32  operand width in bits; product is 2*WIDTH bits; legal values are >= 4
// PORTS
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous, active-low reset (0 = reset)
//   start     in   1        request; sampled only in IDLE
//   op        in   2        00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   a         in   WIDTH    multiplicand / dividend
//   b         in   WIDTH    multiplier / divisor
//   busy      out  1        high while an operation is in flight
//   done      out  1        one-cycle pulse when hi/lo are valid
//   hi        out  WIDTH    MULT: product[2W-1:W];  DIV: remainder
//   lo        out  WIDTH    MULT: product[W-1:0];   DIV: quotient
//   div_zero  out  1        set when a DIV/DIVU has divisor 0
// BEHAVIOUR
//   Reset (reset=0, asynchronous)
//     - Outputs: busy=0, done=0, hi=0, lo=0, div_zero=0.
//     - Internals: state=IDLE, all internal registers cleared.
//     - Reset mid-operation aborts with no done pulse.
//   States: IDLE -> CALC -> FIN -> IDLE
//   Edge E0 (IDLE, start=1)
//     - Latch op, |a|, |b| and the result signs; iteration counter=0.
//     - Clear div_zero; state=CALC; busy=1.
//     - a/b may change after E0 without effect.
//     - DIV/DIVU with b==0: state=FIN directly, no iterations.
//   CALC (edges E1..E_WIDTH, one step per edge)
//     - MULT: shift-add on magnitudes into a 2W accumulator.
//     - DIV: restoring division. Shift in the dividend MSB-first; subtract the divisor
//       if the partial remainder >= divisor; quotient bit = 1 on subtract.
//   FIN (edge E_WIDTH+1)
//     - Apply sign correction, write hi/lo, pulse done=1 for one cycle, busy=0, state=IDLE.
//     - Divide-by-zero: div_zero=1 and done=1 at E1; hi/lo keep their previous values.
//   Latency
//     - done is high in the cycle after edge E0+WIDTH+1.
//     - A new start is accepted on the edge where done is high (back-to-back operation).
//   Start handling
//     - start while busy is ignored; no queueing.
//   Sign rules (signed ops)
//     - product is negated if sign(a) xor sign(b).
//     - quotient is truncated toward zero; remainder takes the sign of the dividend.
//     - Magnitude of the most-negative value is 2^(W-1), held in W bits unsigned, so no overflow internally.
//   Boundary cases
//     - DIV of most-negative by -1: lo = most-negative (wraps), hi=0, no flag.
//     - Unsigned ops: no sign handling; operands are treated as W-bit magnitudes.
//   Output holding
//     - hi/lo/div_zero hold their values through IDLE.
//     - div_zero is cleared only by the next accepted start or by reset.
// TESTING (WIDTH=32)
//   - MULT a=-7 (FFFFFFF9), b=6 -> hi=FFFFFFFF lo=FFFFFFD6; done exactly 33 edges after start edge.
//   - MULT a=80000000, b=80000000 -> hi=40000000 lo=0; MULTU a=b=FFFFFFFF -> hi=FFFFFFFE lo=1.
//   - DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIVU a=7,b=2 -> lo=3, hi=1.
//   - DIV b=0 -> div_zero=1, done at E1, hi/lo unchanged; next MULT start clears div_zero.
//   - DIV a=80000000, b=FFFFFFFF -> lo=80000000 hi=0; start pulses while busy are ignored, result unaffected.
//   - reset low at iteration 10 -> all outputs 0 immediately, no done; fresh start afterwards returns correct result.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply-divide unit for the HI/LO register pair.
// One shift-add or restoring-divide step per cycle; result every WIDTH+2 cycles.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             is_div, neg_main, neg_rem, dz_pend;

  logic             zero_div_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;
  logic [WIDTH:0]   add_c, shl_c, sub_c;
  logic [AW-1:0]    mul_step_c, div_step_c, prod_c;
  logic [WIDTH-1:0] quot_c, rem_c;

  // Operand magnitudes; unsigned ops pass operands through untouched
  always_comb begin
    zero_div_c = op[1] && (b == '0);
    mag_a_c    = (!op[0] && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_c    = (!op[0] && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Iteration step: multiplier sits in acc low half, partial product shifts in from the top.
  // For divide, acc = {partial remainder, dividend/quotient}.
  always_comb begin
    add_c      = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opnd};
    mul_step_c = acc[0] ? {add_c, acc[WIDTH-1:1]}
                        : {1'b0, acc[AW-1:WIDTH], acc[WIDTH-1:1]};
    shl_c      = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    sub_c      = shl_c - {1'b0, opnd};
    div_step_c = sub_c[WIDTH] ? {shl_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {sub_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_c     = neg_main ? (~acc + AW'(1)) : acc;
    quot_c     = neg_main ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_c      = neg_rem ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div_c ? FIN : CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      dz_pend  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          is_div   <= op[1];
          neg_main <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem  <= !op[0] && a[WIDTH-1];
          dz_pend  <= zero_div_c;
          cnt      <= '0;
          div_zero <= 1'b0;
          busy     <= 1'b1;
          acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a_c : mag_b_c)};
          opnd     <= op[1] ? mag_b_c : mag_a_c;
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          acc <= is_div ? div_step_c : mul_step_c;
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dz_pend) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_c;
            lo <= quot_c;
          end else begin
            hi <= prod_c[AW-1:WIDTH];
            lo <= prod_c[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results from an
// arithmetic reference model; a negedge monitor pops and compares on every done.
module tb_mult_div_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  due;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero, '%' follows the dividend
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dz = 1'b0;
    case (o)
      2'd0: begin p = 64'(sx * sy); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (y == '0) begin
          e.dz = 1'b1; e.hi = m_hi; e.lo = m_lo;
        end else if (o == 2'd2) begin
          q = sx / sy; r = sx % sy;
          e.lo = 32'(q); e.hi = 32'(r);
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
      end
    endcase
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  // Issue one operation from a negedge once the unit is free; optionally pulse start while busy
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit noise);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL issue_wait actual=busy required=idle");
    end
    op = o; a = x; b = y; start = 1'b1;
    model(o, x, y, e);
    e.due = cyc + ((e.dz) ? 2 : W + 2);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    if (noise) begin
      repeat (3) begin
        @(negedge clk);
        if (busy) begin
          start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (sbq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("div_zero", div_zero, e.dz);
        check("latency_cycle", cyc, e.due);
        check("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;

    issue(2'd0, 32'hFFFF_FFF9, 32'd6, 1'b0);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'd3, 32'd7, 32'd2, 1'b0);
    issue(2'd2, 32'd1234, 32'd0, 1'b0);
    issue(2'd0, 32'd3, 32'd5, 1'b0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    issue(2'd3, 32'd5, 32'd0, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    check("div_zero_hold", div_zero, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = {28'b0, 4'($urandom)};
      issue(ro, ra, rb, ($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset in the middle of an operation: everything clears, no done follows
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_div_zero", div_zero, 0);
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(2'd2, 32'hFFFF_FF9C, 32'd7, 1'b0);
    issue(2'd3, 32'd100, 32'd0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
